// File: rtl/scramble_move_generator.sv
// Turns a rising edge on random_please into a burst of NUM_MOVES LFSR-derived move codes,
// each in range and different from the previous move, handed out over valid/ready.
module scramble_move_generator #(
    parameter int          NUM_MOVES = 20,
    parameter int          MOVE_W    = 3,
    parameter int          NUM_CODES = 6,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              random_please,
    input  logic              move_ready,
    output logic              move_valid,
    output logic [MOVE_W-1:0] move_code,
    output logic              busy,
    output logic              scramble_done
);

    localparam int                CNT_W      = $clog2(NUM_MOVES + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(NUM_MOVES - 1);
    localparam logic [MOVE_W:0]   CODE_LIMIT = (MOVE_W + 1)'(NUM_CODES);
    localparam logic [15:0]       LFSR_MASK  = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [MOVE_W-1:0] code_q, code_d;
    logic [MOVE_W-1:0] last_code_q, last_code_d;
    logic              move_valid_q, move_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              trig;
    logic [MOVE_W-1:0] cand;
    logic              cand_ok;

    always_comb begin
        // The LFSR free-runs in every state so request timing perturbs the sequence.
        lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        req_d   = random_please;
        trig    = random_please & ~req_q;
        cand    = lfsr_q[MOVE_W-1:0];
        cand_ok = ({1'b0, cand} < CODE_LIMIT) &&
                  !((count_q != '0) && (cand == last_code_q));

        state_d     = state_q;
        count_d     = count_q;
        code_d      = code_q;
        last_code_d = last_code_q;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    count_d = '0;
                    state_d = S_GEN;
                end
            end
            S_GEN: begin
                if (cand_ok) begin
                    code_d  = cand;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // move_valid is high throughout ISSUE, so ready alone completes the transfer.
                if (move_ready) begin
                    last_code_d = code_q;
                    count_d     = count_q + CNT_W'(1);
                    state_d     = (count_q == LAST_CNT) ? S_DONE : S_GEN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        move_valid_d = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED;
            req_q        <= 1'b0;
            count_q      <= '0;
            code_q       <= '0;
            last_code_q  <= '0;
            move_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            req_q        <= req_d;
            count_q      <= count_d;
            code_q       <= code_d;
            last_code_q  <= last_code_d;
            move_valid_q <= move_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign move_valid    = move_valid_q;
    assign move_code     = code_q;
    assign busy          = busy_q;
    assign scramble_done = done_q;

endmodule

// File: doc/scramble_move_generator.md
# scramble_move_generator

Downstream of the shuffle/solve state block. Turns that block's `RandomPlease` request into a burst of `NUM_MOVES` pseudo-random puzzle move codes and delivers them one at a time over a valid/ready handshake to the puzzle-state update logic. Moves come from a free-running 16-bit LFSR. Each code is range-checked and must differ from the previous move.

## Interface
- `NUM_MOVES`, default 20: moves per scramble burst; must be ≥1.
- `MOVE_W`, default 3: width of the move code.
- `NUM_CODES`, default 6: number of legal move codes (0..NUM_CODES-1); 2 ≤ NUM_CODES ≤ 2**MOVE_W.
- `SEED`, default 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `random_please`, in, 1: scramble request (level) from the shuffle/solve state block.
- `move_ready`, in, 1: consumer accepts the current move this cycle.
- `move_valid`, out, 1: `move_code` is valid.
- `move_code`, out, MOVE_W: move to apply.
- `busy`, out, 1: a burst is in progress.
- `scramble_done`, out, 1: one-cycle pulse after the last move is accepted.

## Operation
- **Clock and reset.** One clock; reset is asynchronous and active-low.
- **LFSR.**
  - 16-bit Galois, right-shift, mask 16'hB400.
  - Each cycle: `lsb = lfsr[0]`, `lfsr = lfsr >> 1`, XOR with the mask if `lsb` is 1.
  - Advances every cycle in every state, so button timing adds entropy.
  - Reset value is `SEED`. It never reaches zero.
- **Edge detect.** `req_q` registers `random_please`. A trigger is `random_please & ~req_q`.
  - Holding the level does not retrigger.
  - Triggers while not IDLE are ignored and not queued.
- **Candidate code.** `cand = lfsr[MOVE_W-1:0]`, the current register value.
- **State machine:**
  - **IDLE.** `busy=0`. On trigger: `count←0`, go to GEN.
  - **GEN.** `busy=1`, `move_valid=0`.
    - Reject `cand` if `cand ≥ NUM_CODES`, or if `count>0` and `cand == last_code`. On reject, stay in GEN and retry next cycle.
    - Otherwise `code_r←cand` and go to ISSUE.
  - **ISSUE.** `move_valid=1`, `move_code=code_r`, both held stable until `move_ready`.
    - On the handshake (`move_valid & move_ready`): `last_code←code_r`, `count←count+1`.
    - If `count == NUM_MOVES-1`, go to DONE; else go to GEN.
  - **DONE.** `scramble_done=1` for exactly one cycle, `busy=1`, then go to IDLE.
- **Widths.** `count` is `$clog2(NUM_MOVES+1)` bits and never wraps within a burst.
- **Output values.**
  - `move_code` shows `code_r` at all times; it is meaningful only when `move_valid=1`.
  - `move_valid` is asserted only in ISSUE.
- **Reset mid-burst.** Everything returns to reset state immediately. No partial `scramble_done`. The burst is abandoned.

## Timing
- **Reset values.**
  - Outputs: `move_valid=0`, `move_code=0`, `busy=0`, `scramble_done=0`.
  - Internal: `lfsr=SEED`, `req_q=0`, `last_code=0`, `count=0`, state IDLE.
- **Trigger latency.** `random_please` sampled high (with `req_q` low) at edge k puts the FSM in GEN after edge k. The earliest `move_valid=1` is after edge k+1.
- **Per-move cost.** 1 cycle in GEN plus one cycle per rejected candidate.
  - With `move_ready` held high, an accepted move takes 2 cycles minimum.
  - The minimum burst is 2·NUM_MOVES + 1 cycles (including DONE).
- **Handshake.** The transfer occurs on the edge where both `move_valid` and `move_ready` are high.
  - `move_ready` while `move_valid=0` has no effect.
  - The consumer may stall indefinitely; the LFSR keeps running.
- **`scramble_done`.** Asserts the cycle after the final handshake edge. `busy` drops one cycle later.
- **Trigger during DONE.** Ignored. A new burst needs a fresh rising edge once back in IDLE.

## Test plan
- **Reset.** Assert `rst_n=0` mid-cycle with clock running → all outputs 0 asynchronously. One cycle after release, LFSR is 16'hE270.
- **Default burst.** `random_please` 0→1, `move_ready=1` → exactly 20 handshakes, then one `scramble_done` pulse, then `busy=0`.
  - Every code is < 6.
  - No two consecutive codes are equal.
  - First `move_valid` appears no earlier than 2 cycles after the trigger edge.
- **Back-pressure.** `move_ready=0` for 7 cycles during ISSUE → `move_valid` stays 1 and `move_code` is unchanged. The move is counted once when `move_ready` rises.
- **Retrigger suppression.**
  - `random_please` held high for 100 cycles → only one burst.
  - Pulses during the burst and during DONE → no extra moves and no second `scramble_done`.
- **Reset mid-burst.** `rst_n` low after the 5th handshake → `move_valid`, `busy` and `scramble_done` go to 0 immediately.
  - The next trigger yields a full 20-move burst.
- **Parameter corner.** `NUM_MOVES=1`, `NUM_CODES=5`, `MOVE_W=3` → a single move < 5, then `scramble_done`. Rejected candidates 5–7 add GEN cycles only.
